// File: rtl/switch_fabric_pkg.sv
// Shared definitions for the switch-fabric egress path: flit geometry,
// field positions and the serializer state encoding.
package switch_fabric_pkg;

  function automatic int flit_width(input int data_w, input int addr_w, input int vc_w);
    return data_w + addr_w + vc_w + 3;
  endfunction

  // Control bits sit at the top of the flit, above vc/dest/data.
  function automatic int valid_bit(input int fw);
    return fw - 1;
  endfunction

  function automatic int head_bit(input int fw);
    return fw - 2;
  endfunction

  function automatic int tail_bit(input int fw);
    return fw - 3;
  endfunction

  localparam int DATA_WIDTH_DEF       = 128;
  localparam int ADDRESS_WIDTH_DEF    = 4;
  localparam int VC_ADDRESS_WIDTH_DEF = 1;
  localparam int FLIT_WIDTH_DEF       = flit_width(DATA_WIDTH_DEF, ADDRESS_WIDTH_DEF,
                                                   VC_ADDRESS_WIDTH_DEF);

  localparam int VALID_BIT = valid_bit(FLIT_WIDTH_DEF);
  localparam int HEAD_BIT  = head_bit(FLIT_WIDTH_DEF);
  localparam int TAIL_BIT  = tail_bit(FLIT_WIDTH_DEF);
  localparam int VC_MSB    = TAIL_BIT - 1;
  localparam int VC_LSB    = DATA_WIDTH_DEF + ADDRESS_WIDTH_DEF;
  localparam int DEST_MSB  = VC_LSB - 1;
  localparam int DEST_LSB  = DATA_WIDTH_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/flit_serializer_if.sv
// Wide-word handshake between the fabric aggregation stage and the serializer.
interface flit_serializer_if #(
  parameter int WORD_WIDTH = 4 * 136
);
  logic [WORD_WIDTH-1:0] i_data_in;
  logic                  i_valid_in;
  logic                  o_ready_in;

  modport master (output i_data_in, output i_valid_in, input o_ready_in);
  modport slave  (input i_data_in, input i_valid_in, output o_ready_in);
endinterface

// File: rtl/flit_serializer_slot_select.sv
// Lowest-set-bit priority encoder used to pick the next pending flit slot.
module slot_select #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/flit_serializer.sv
// Serializes a word of NOC_SPEEDUP packed flits onto one credit-controlled router port.
// Optional framing/credit checker: define FLIT_SERIALIZER_PROTO_CHECK_EN.
module flit_serializer
  import switch_fabric_pkg::*;
#(
  parameter  int DATA_WIDTH       = 128,
  parameter  int ADDRESS_WIDTH    = 4,
  parameter  int VC_ADDRESS_WIDTH = 1,
  parameter  int NOC_SPEEDUP      = 4,
  parameter  int BUFFER_DEPTH     = 8,
  localparam int FLIT_WIDTH       = flit_width(DATA_WIDTH, ADDRESS_WIDTH, VC_ADDRESS_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  flit_serializer_if.slave      word,
  output logic [FLIT_WIDTH-1:0] o_flit_out,
  output logic                  o_flit_valid,
  input  logic                  i_credit_in,
  output logic                  o_proto_err
);

  localparam int IDX_W  = (NOC_SPEEDUP > 1) ? $clog2(NOC_SPEEDUP) : 1;
  localparam int CRED_W = $clog2(BUFFER_DEPTH + 1);
  localparam int VB     = valid_bit(FLIT_WIDTH);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_DEPTH);

  state_t                 state, state_d;
  logic [NOC_SPEEDUP-1:0] pend_mask, pend_mask_d, in_mask, rest_mask;
  logic [FLIT_WIDTH-1:0]  hold [NOC_SPEEDUP];
  logic [FLIT_WIDTH-1:0]  cur_flit;
  logic [CRED_W-1:0]      credits;
  logic [IDX_W-1:0]       sel;
  logic                   any_pend, send, last, ready, accept;

  always_comb begin
    for (int s = 0; s < NOC_SPEEDUP; s++) begin
      in_mask[s] = word.i_data_in[s*FLIT_WIDTH + VB];
    end
  end

  slot_select #(.N(NOC_SPEEDUP)) u_slot_select (
    .mask (pend_mask),
    .idx  (sel),
    .any  (any_pend)
  );

  assign cur_flit  = hold[sel];
  assign rest_mask = pend_mask & ~(NOC_SPEEDUP'(1) << sel);
  assign send      = (state == SEND) && any_pend && (credits != '0);
  // Finishing the last pending flit frees the hold register in the same cycle.
  assign last      = send && (rest_mask == '0);
  assign ready     = (state == IDLE) || last;
  assign accept    = word.i_valid_in && ready;

  assign word.o_ready_in = ready;

  always_comb begin
    state_d      = state;
    pend_mask_d  = pend_mask;
    o_flit_out   = '0;
    o_flit_valid = 1'b0;
    case (state)
      IDLE: ;
      SEND: begin
        o_flit_out   = cur_flit;
        o_flit_valid = send;
        if (send) begin
          pend_mask_d = rest_mask;
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A word with no valid slots is dropped without leaving IDLE.
    if (accept) begin
      pend_mask_d = in_mask;
      state_d     = (|in_mask) ? SEND : IDLE;
    end
  end

  // ---- stage boundary: control state and credit counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_mask <= '0;
    end else begin
      state     <= state_d;
      pend_mask <= pend_mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else if (send && !i_credit_in) begin
      credits <= credits - CRED_W'(1);
    end else if (!send && i_credit_in && (credits != CRED_MAX)) begin
      credits <= credits + CRED_W'(1);
    end
  end

  // ---- stage boundary: hold register (datapath, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int s = 0; s < NOC_SPEEDUP; s++) begin
        hold[s] <= word.i_data_in[s*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

`ifdef FLIT_SERIALIZER_PROTO_CHECK_EN
  localparam int HB = head_bit(FLIT_WIDTH);
  localparam int TB = tail_bit(FLIT_WIDTH);

  logic pkt_open, proto_err, head, tail, bad;

  assign head = cur_flit[HB];
  assign tail = cur_flit[TB];
  // A head must find no open packet and any other flit must find one.
  assign bad  = (send && (head == pkt_open)) || (i_credit_in && (credits == CRED_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_open  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (bad) proto_err <= 1'b1;
      if (send) pkt_open <= tail ? 1'b0 : (head ? 1'b1 : pkt_open);
    end
  end

  assign o_proto_err = proto_err;
`else
  assign o_proto_err = 1'b0;
`endif

endmodule
